// File: rtl/pcw_pulse_pkg.sv
// Shared types and defaults for the strobe-to-pulse generator.
// Imported by pulse_gen and its down-counter.
package pcw_pulse_pkg;

    localparam int PULSE_CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELAY   = 2'd1,
        ACTIVE  = 2'd2,
        HOLDOFF = 2'd3
    } pulse_state_t;

endpackage

// File: rtl/pulse_cnt.sv
// Loadable down-counter that stops at zero; a load wins over counting and ignores ce.
// zero flags the terminal count for the controlling FSM.
module pulse_cnt
    import pcw_pulse_pkg::*;
#(
    parameter int CNT_W = PULSE_CNT_W_DEFAULT
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             ce,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (ce && (cnt != '0)) begin
            cnt <= cnt - ONE;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_gen.sv
// Turns a single-cycle trig strobe into a delayed, timed level pulse followed by dead time.
// All timing advances on ce ticks; trig itself is honoured on any clk_sys cycle.
module pulse_gen
    import pcw_pulse_pkg::*;
#(
    parameter int CNT_W = PULSE_CNT_W_DEFAULT
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             ce,
    input  logic             trig,
    input  logic [CNT_W-1:0] delay,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] holdoff,
    input  logic             retrig_en,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic             missed
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    pulse_state_t     state;
    pulse_state_t     state_nx;
    logic [CNT_W-1:0] width_l;
    logic [CNT_W-1:0] holdoff_l;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] cnt_unused;
    logic             load;
    logic             cnt_zero;
    logic             accept;
    logic             done_nx;
    logic             missed_nx;

    // A zero width still produces one tick of pulse.
    function automatic logic [CNT_W-1:0] width_cnt(input logic [CNT_W-1:0] w);
        return (w == '0) ? '0 : (w - ONE);
    endfunction

    pulse_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ce       (ce),
        .load     (load),
        .load_val (load_val),
        .cnt      (cnt_unused),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_nx  = state;
        load      = 1'b0;
        load_val  = '0;
        accept    = 1'b0;
        done_nx   = 1'b0;
        missed_nx = 1'b0;
        case (state)
            IDLE: begin
                if (trig) begin
                    accept = 1'b1;
                    load   = 1'b1;
                    if (delay == '0) begin
                        state_nx = ACTIVE;
                        load_val = width_cnt(width);
                    end else begin
                        state_nx = DELAY;
                        load_val = delay - ONE;
                    end
                end
            end
            DELAY: begin
                missed_nx = trig;
                if (ce && cnt_zero) begin
                    state_nx = ACTIVE;
                    load     = 1'b1;
                    load_val = width_cnt(width_l);
                end
            end
            ACTIVE: begin
                // A retrigger takes priority over expiry on the same cycle.
                if (trig && retrig_en) begin
                    load     = 1'b1;
                    load_val = width_cnt(width_l);
                end else begin
                    missed_nx = trig;
                    if (ce && cnt_zero) begin
                        done_nx = 1'b1;
                        if (holdoff_l != '0) begin
                            state_nx = HOLDOFF;
                            load     = 1'b1;
                            load_val = holdoff_l - ONE;
                        end else begin
                            state_nx = IDLE;
                        end
                    end
                end
            end
            HOLDOFF: begin
                missed_nx = trig;
                if (ce && cnt_zero) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            width_l   <= '0;
            holdoff_l <= '0;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            missed    <= 1'b0;
        end else begin
            state     <= state_nx;
            pulse_out <= (state_nx == ACTIVE);
            busy      <= (state_nx != IDLE);
            done      <= done_nx;
            missed    <= missed_nx;
            if (accept) begin
                width_l   <= width;
                holdoff_l <= holdoff;
            end
        end
    end

endmodule

// File: tb/tb_pulse_gen.sv
// Bench for pulse_gen: directed scenarios plus randomized traffic against a tick-counting model.
module tb_pulse_gen;

    localparam int CNT_W = 16;

    logic             clk_sys = 1'b0;
    logic             reset;
    logic             ce;
    logic             trig;
    logic [CNT_W-1:0] delay;
    logic [CNT_W-1:0] width;
    logic [CNT_W-1:0] holdoff;
    logic             retrig_en;
    logic             pulse_out;
    logic             busy;
    logic             done;
    logic             missed;

    int checks = 0;
    int errors = 0;

    // Model: phase 0 idle, 1 waiting, 2 high, 3 dead; ticks_left counts ce ticks still to elapse.
    int phase;
    int ticks_left;
    int lat_w;
    int lat_h;
    bit e_pulse, e_busy, e_done, e_missed;

    logic [3:0] obs  [0:255];
    logic [3:0] expv [0:255];

    always #5 clk_sys = ~clk_sys;

    pulse_gen #(.CNT_W(CNT_W)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ce        (ce),
        .trig      (trig),
        .delay     (delay),
        .width     (width),
        .holdoff   (holdoff),
        .retrig_en (retrig_en),
        .pulse_out (pulse_out),
        .busy      (busy),
        .done      (done),
        .missed    (missed)
    );

    function automatic void model_reset();
        phase = 0; ticks_left = 0; lat_w = 0; lat_h = 0;
        e_pulse = 0; e_busy = 0; e_done = 0; e_missed = 0;
    endfunction

    function automatic void model_edge(bit t, bit c, int d, int w, int h, bit re);
        e_done = 0;
        e_missed = 0;
        case (phase)
            0: if (t) begin
                lat_w = (w == 0) ? 1 : w;
                lat_h = h;
                if (d == 0) begin phase = 2; ticks_left = lat_w; end
                else begin phase = 1; ticks_left = d; end
            end
            1: begin
                if (t) e_missed = 1;
                if (c) begin
                    ticks_left--;
                    if (ticks_left == 0) begin phase = 2; ticks_left = lat_w; end
                end
            end
            2: begin
                if (t && re) ticks_left = lat_w;
                else begin
                    if (t) e_missed = 1;
                    if (c) begin
                        ticks_left--;
                        if (ticks_left == 0) begin
                            e_done = 1;
                            if (lat_h != 0) begin phase = 3; ticks_left = lat_h; end
                            else phase = 0;
                        end
                    end
                end
            end
            default: begin
                if (t) e_missed = 1;
                if (c) begin
                    ticks_left--;
                    if (ticks_left == 0) phase = 0;
                end
            end
        endcase
        e_pulse = (phase == 2);
        e_busy  = (phase != 0);
    endfunction

    task automatic tick();
        bit t, c, re, r;
        int d, w, h;
        t = trig; c = ce; re = retrig_en; r = reset;
        d = int'(delay); w = int'(width); h = int'(holdoff);
        @(posedge clk_sys);
        if (r) model_reset();
        else model_edge(t, c, d, w, h, re);
        #1;
    endtask

    // Drives one scenario and records DUT and model outputs per cycle; no comparisons here.
    task automatic run_scn(input int d, input int w, input int h, input bit re, input int cediv,
                           input int t0, input int t1, input int t2, input int n);
        for (int k = 0; k < n; k++) begin
            delay = CNT_W'(d); width = CNT_W'(w); holdoff = CNT_W'(h);
            retrig_en = re;
            ce   = ((k % cediv) == 0);
            trig = (k == t0) || (k == t1) || (k == t2);
            tick();
            obs[k]  = {pulse_out, busy, done, missed};
            expv[k] = {e_pulse, e_busy, e_done, e_missed};
        end
        trig = 1'b0;
        ce = 1'b1;
    endtask

    function automatic int count_hi(int b, int n);
        int s = 0;
        for (int k = 0; k < n; k++) if (obs[k][b] === 1'b1) s++;
        return s;
    endfunction

    function automatic int first_hi(int b, int n);
        for (int k = 0; k < n; k++) if (obs[k][b] === 1'b1) return k;
        return -1;
    endfunction

    task automatic test_reset();
        reset = 1'b1; ce = 1'b1; trig = 1'b0; retrig_en = 1'b0;
        delay = '0; width = '0; holdoff = '0;
        model_reset();
        @(posedge clk_sys); #1;
        checks++;
        if ({pulse_out, busy, done, missed} !== 4'b0000) begin
            errors++; $display("FAIL reset_outputs got %b want 0000", {pulse_out, busy, done, missed});
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({pulse_out, busy, done, missed} !== {e_pulse, e_busy, e_done, e_missed}) begin
            errors++; $display("FAIL reset_idle got %b want %b", {pulse_out, busy, done, missed},
                               {e_pulse, e_busy, e_done, e_missed});
        end
    endtask

    task automatic test_single();
        int fh;
        run_scn(0, 3, 0, 0, 1, 10, -1, -1, 20);
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (obs[k] !== expv[k]) begin
                errors++; $display("FAIL single_trace cyc %0d got %b want %b", k, obs[k], expv[k]);
            end
        end
        fh = first_hi(3, 20);
        checks++;
        if (fh != 10) begin errors++; $display("FAIL single_rise got %0d want 10", fh); end
        checks++;
        if (count_hi(3, 20) != 3) begin errors++; $display("FAIL single_width got %0d want 3", count_hi(3, 20)); end
        checks++;
        if (first_hi(1, 20) != fh + 3 || count_hi(1, 20) != 1) begin
            errors++; $display("FAIL single_done at %0d want %0d", first_hi(1, 20), fh + 3);
        end
    endtask

    task automatic test_holdoff();
        run_scn(4, 2, 5, 0, 1, 0, 10, 12, 32);
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (obs[k] !== expv[k]) begin
                errors++; $display("FAIL holdoff_trace cyc %0d got %b want %b", k, obs[k], expv[k]);
            end
        end
        checks++;
        if (first_hi(3, 32) != 4) begin errors++; $display("FAIL holdoff_rise got %0d want 4", first_hi(3, 32)); end
        checks++;
        if (obs[10][2] !== 1'b1 || obs[11][2] !== 1'b0) begin
            errors++; $display("FAIL holdoff_busy got %b%b want 10", obs[10][2], obs[11][2]);
        end
        checks++;
        if (first_hi(0, 32) != 10 || count_hi(0, 32) != 1) begin
            errors++; $display("FAIL holdoff_missed at %0d want 10", first_hi(0, 32));
        end
        checks++;
        if (obs[12][2] !== 1'b1 || count_hi(3, 32) != 4) begin
            errors++; $display("FAIL holdoff_accept busy %b highs %0d want 1 4", obs[12][2], count_hi(3, 32));
        end
    endtask

    task automatic test_retrig(input bit re);
        run_scn(0, 4, 0, re, 1, 0, 3, -1, 16);
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (obs[k] !== expv[k]) begin
                errors++; $display("FAIL retrig%0d_trace cyc %0d got %b want %b", re, k, obs[k], expv[k]);
            end
        end
        checks++;
        if (count_hi(3, 16) != (re ? 7 : 4)) begin
            errors++; $display("FAIL retrig%0d_width got %0d want %0d", re, count_hi(3, 16), re ? 7 : 4);
        end
        checks++;
        if (count_hi(1, 16) != 1) begin errors++; $display("FAIL retrig%0d_done got %0d want 1", re, count_hi(1, 16)); end
        checks++;
        if (count_hi(0, 16) != (re ? 0 : 1)) begin
            errors++; $display("FAIL retrig%0d_missed got %0d want %0d", re, count_hi(0, 16), re ? 0 : 1);
        end
    endtask

    task automatic test_ce_div();
        int fh;
        run_scn(1, 2, 0, 0, 4, 0, -1, -1, 24);
        for (int k = 0; k < 24; k++) begin
            checks++;
            if (obs[k] !== expv[k]) begin
                errors++; $display("FAIL cediv_trace cyc %0d got %b want %b", k, obs[k], expv[k]);
            end
        end
        fh = first_hi(3, 24);
        checks++;
        if (count_hi(3, 24) != 8 || (fh % 4) != 0) begin
            errors++; $display("FAIL cediv_high got %0d at %0d want 8 ce-aligned", count_hi(3, 24), fh);
        end
    endtask

    task automatic test_width0();
        run_scn(0, 0, 0, 0, 1, 2, -1, -1, 8);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (obs[k] !== expv[k]) begin
                errors++; $display("FAIL width0_trace cyc %0d got %b want %b", k, obs[k], expv[k]);
            end
        end
        checks++;
        if (count_hi(3, 8) != 1) begin errors++; $display("FAIL width0_len got %0d want 1", count_hi(3, 8)); end
    endtask

    task automatic test_async_reset();
        delay = '0; width = CNT_W'(100); holdoff = '0; retrig_en = 1'b0; ce = 1'b1;
        trig = 1'b1; tick(); trig = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (pulse_out !== e_pulse || e_pulse != 1'b1) begin
            errors++; $display("FAIL areset_pre got %b want 1", pulse_out);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({pulse_out, busy, done, missed} !== 4'b0000) begin
            errors++; $display("FAIL areset_drop got %b want 0000", {pulse_out, busy, done, missed});
        end
        tick();
        checks++;
        if ({pulse_out, busy, done, missed} !== 4'b0000) begin
            errors++; $display("FAIL areset_hold got %b want 0000", {pulse_out, busy, done, missed});
        end
        reset = 1'b0;
        run_scn(0, 2, 0, 0, 1, 1, -1, -1, 8);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (obs[k] !== expv[k]) begin
                errors++; $display("FAIL areset_after cyc %0d got %b want %b", k, obs[k], expv[k]);
            end
        end
        checks++;
        if (count_hi(3, 8) != 2) begin errors++; $display("FAIL areset_len got %0d want 2", count_hi(3, 8)); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            ce        = ($urandom_range(0, 2) != 0);
            trig      = ($urandom_range(0, 6) == 0);
            retrig_en = $urandom_range(0, 1) == 1;
            delay     = CNT_W'($urandom_range(0, 4));
            width     = CNT_W'($urandom_range(0, 5));
            holdoff   = CNT_W'($urandom_range(0, 4));
            tick();
            checks++;
            if ({pulse_out, busy, done, missed} !== {e_pulse, e_busy, e_done, e_missed}) begin
                errors++; $display("FAIL random cyc %0d got %b want %b", k,
                                   {pulse_out, busy, done, missed}, {e_pulse, e_busy, e_done, e_missed});
            end
        end
        trig = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_holdoff();
        test_retrig(1'b1);
        test_retrig(1'b0);
        test_ce_div();
        test_width0();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
